// File: rtl/drv7seg_rx_pkg.sv
// Shared constants for the 7-segment bus receiver: canonical segment codes,
// segment bit positions and the frame FSM state type.
package drv7seg_rx_pkg;

  localparam int SEG_DP = 7;
  localparam int SEG_G  = 6;
  localparam int SEG_F  = 5;
  localparam int SEG_E  = 4;
  localparam int SEG_D  = 3;
  localparam int SEG_C  = 2;
  localparam int SEG_B  = 1;
  localparam int SEG_A  = 0;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // {g..a} codes, element i displays hex digit i
  localparam logic [15:0][6:0] SEG_CODES = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic [1:0] {IDLE, COLLECT, PUBLISH} frame_state_e;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] enc4(input logic [3:0] v);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
    return r;
  endfunction

endpackage

// File: rtl/drv7seg_rx_if.sv
// Pin bundle of the 7-segment bus receiver: tapped COM/segment lines in,
// decoded frame out.
interface drv7seg_rx_if;
  logic [3:0] I_COM;
  logic [7:0] I_DRV7SEG;
  logic [3:0] O_DG3, O_DG2, O_DG1, O_DG0;
  logic [3:0] O_DOTS;
  logic [3:0] O_DRVEN;
  logic       O_VALID;
  logic       O_ERR;

  modport master (output I_COM, I_DRV7SEG,
                  input  O_DG3, O_DG2, O_DG1, O_DG0, O_DOTS, O_DRVEN, O_VALID, O_ERR);
  modport slave  (input  I_COM, I_DRV7SEG,
                  output O_DG3, O_DG2, O_DG1, O_DG0, O_DOTS, O_DRVEN, O_VALID, O_ERR);
endinterface

// File: rtl/drv7seg_rx_seg7_decode.sv
// Combinational 7-segment to hex decoder; blank and unknown codes both
// return value 0 and are told apart by the flags.
module seg7_decode
  import drv7seg_rx_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       blank,
  output logic       invalid
);

  always_comb begin
    value   = '0;
    blank   = (seg == SEG_BLANK);
    invalid = ~blank;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_CODES[i]) begin
        value   = 4'(i);
        invalid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/drv7seg_rx.sv
// Receiver for the multiplexed 4-digit 7-segment bus: sync, glitch filter,
// per-digit decode and one published frame per scan.
// Optional idle timeout publish is built when DRV7SEGRX_TIMEOUT_EN is defined.
module drv7seg_rx
  import drv7seg_rx_pkg::*;
#(
  parameter int STABLE_CYC     = 4,
  parameter int TIMEOUT_CYC    = 4096,
  parameter bit COM_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
)(
  input  logic          I_CLK,
  input  logic          I_RESET,
  drv7seg_rx_if.slave   bus
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] CNT_ACC = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_CYC);

  logic [3:0]  com_m, com_s, com_n;
  logic [7:0]  seg_m, seg_s, seg_n;
  logic [11:0] pat_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      com_m <= '0; com_s <= '0;
      seg_m <= '0; seg_s <= '0;
    end else begin
      com_m <= bus.I_COM;     com_s <= com_m;
      seg_m <= bus.I_DRV7SEG; seg_s <= seg_m;
    end
  end

  assign com_n = COM_ACTIVE_LOW ? ~com_s : com_s;
  assign seg_n = SEG_ACTIVE_LOW ? ~seg_s : seg_s;

  // Counter saturates at STABLE_CYC so a long stable run accepts only once
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      pat_q <= '0;
      cnt_q <= '0;
    end else begin
      pat_q <= {com_n, seg_n};
      if ({com_n, seg_n} != pat_q) cnt_q <= '0;
      else if (cnt_q != CNT_SAT)   cnt_q <= cnt_q + 1'b1;
    end
  end

  logic       acc, acc_one, acc_multi;
  logic [1:0] acc_idx;
  logic [3:0] cur_val;
  logic       cur_blank, cur_inv;

  assign acc       = (cnt_q == CNT_ACC);
  assign acc_one   = acc & is_onehot4(pat_q[11:8]);
  assign acc_multi = acc & (|pat_q[11:8]) & ~is_onehot4(pat_q[11:8]);
  assign acc_idx   = enc4(pat_q[11:8]);

  seg7_decode u_dec (
    .seg     (pat_q[6:0]),
    .value   (cur_val),
    .blank   (cur_blank),
    .invalid (cur_inv)
  );

  frame_state_e state_q, state_d;
  logic cap, cap_from_pend, clr_sh, ld_pend, pub, tmo;

  logic [1:0] pend_idx;
  logic [3:0] pend_val;
  logic       pend_blank, pend_inv, pend_dp, pend_vld;

  logic [3:0][3:0] sh_dg, dg_q;
  logic [3:0]      sh_dots, sh_drven, mask;
  logic [3:0]      dots_q, drven_q;
  logic            ferr, err_q, valid_q;

`ifdef DRV7SEGRX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt_q;

  assign tmo = (tcnt_q == TW'(TIMEOUT_CYC));

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET)                              tcnt_q <= '0;
    else if (state_q == PUBLISH || acc || tmo) tcnt_q <= '0;
    else                                      tcnt_q <= tcnt_q + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // A repeated digit closes the frame; it is parked in pend_* and becomes
  // the first capture of the next frame once the publish cycle is done.
  always_comb begin
    state_d       = state_q;
    cap           = 1'b0;
    cap_from_pend = 1'b0;
    clr_sh        = 1'b0;
    ld_pend       = 1'b0;
    pub           = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc_one) begin
          state_d = COLLECT;
          clr_sh  = 1'b1;
          cap     = 1'b1;
        end else if (tmo) begin
          clr_sh  = 1'b1;
          state_d = PUBLISH;
        end
      end
      COLLECT: begin
        if (acc_one) begin
          if (mask[acc_idx]) begin
            ld_pend = 1'b1;
            state_d = PUBLISH;
          end else begin
            cap = 1'b1;
          end
        end else if (tmo) begin
          state_d = PUBLISH;
        end
      end
      PUBLISH: begin
        pub = 1'b1;
        if (pend_vld) begin
          clr_sh        = 1'b1;
          cap           = 1'b1;
          cap_from_pend = 1'b1;
          state_d       = COLLECT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [1:0] cap_idx;
  logic [3:0] cap_val;
  logic       cap_blank, cap_inv, cap_dp;

  assign cap_idx   = cap_from_pend ? pend_idx   : acc_idx;
  assign cap_val   = cap_from_pend ? pend_val   : cur_val;
  assign cap_blank = cap_from_pend ? pend_blank : cur_blank;
  assign cap_inv   = cap_from_pend ? pend_inv   : cur_inv;
  assign cap_dp    = cap_from_pend ? pend_dp    : pat_q[SEG_DP];

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      pend_idx <= '0; pend_val <= '0; pend_blank <= 1'b0;
      pend_inv <= 1'b0; pend_dp <= 1'b0; pend_vld <= 1'b0;
      sh_dg <= '0; sh_dots <= '0; sh_drven <= '0; mask <= '0; ferr <= 1'b0;
      dg_q <= '0; dots_q <= '0; drven_q <= '0; err_q <= 1'b0; valid_q <= 1'b0;
    end else begin
      if (ld_pend) begin
        pend_idx   <= acc_idx;
        pend_val   <= cur_val;
        pend_blank <= cur_blank;
        pend_inv   <= cur_inv;
        pend_dp    <= pat_q[SEG_DP];
        pend_vld   <= 1'b1;
      end else if (pub) begin
        pend_vld   <= 1'b0;
      end
      if (clr_sh) begin
        sh_dg <= '0; sh_dots <= '0; sh_drven <= '0; mask <= '0; ferr <= 1'b0;
      end
      if (cap) begin
        sh_dg[cap_idx]    <= cap_val;
        sh_drven[cap_idx] <= ~cap_blank;
        sh_dots[cap_idx]  <= cap_dp;
        mask[cap_idx]     <= 1'b1;
        if (cap_inv) ferr <= 1'b1;
      end
      if (acc_multi) ferr <= 1'b1;
      valid_q <= pub;
      if (pub) begin
        dg_q    <= sh_dg;
        dots_q  <= sh_dots;
        drven_q <= sh_drven;
        err_q   <= ferr;
      end
    end
  end

  assign bus.O_DG3   = dg_q[3];
  assign bus.O_DG2   = dg_q[2];
  assign bus.O_DG1   = dg_q[1];
  assign bus.O_DG0   = dg_q[0];
  assign bus.O_DOTS  = dots_q;
  assign bus.O_DRVEN = drven_q;
  assign bus.O_VALID = valid_q;
  assign bus.O_ERR   = err_q;

endmodule

// File: tb/tb_drv7seg_rx.sv
// Bench for drv7seg_rx: drives active-low scans, predicts each frame from
// the slots that were shown, compares every published frame.
module tb_drv7seg_rx;

  localparam int TMO = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  drv7seg_rx_if bus();

  drv7seg_rx #(
    .STABLE_CYC     (4),
    .TIMEOUT_CYC    (TMO),
    .COM_ACTIVE_LOW (1'b1),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .I_CLK   (clk),
    .I_RESET (rst),
    .bus     (bus)
  );

  typedef struct packed {
    logic [3:0] dg3, dg2, dg1, dg0, dots, drven;
    logic       err;
  } frame_t;

  localparam logic [6:0] CODE_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  frame_t obs_q[$];
  frame_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  always @(negedge clk)
    if (!rst && bus.O_VALID)
      obs_q.push_back({bus.O_DG3, bus.O_DG2, bus.O_DG1, bus.O_DG0,
                       bus.O_DOTS, bus.O_DRVEN, bus.O_ERR});

  function automatic frame_t model(input logic [3:0] pres, input logic [3:0][6:0] code,
                                   input logic [3:0] dp, input bit multi);
    frame_t f;
    logic [3:0][3:0] dg;
    bit hit;
    logic [3:0] v;
    f  = '0;
    dg = '0;
    for (int d = 0; d < 4; d++) begin
      if (!pres[d]) continue;
      f.dots[d] = dp[d];
      if (code[d] == 7'h00) continue;
      f.drven[d] = 1'b1;
      hit = 1'b0;
      v   = '0;
      for (int k = 0; k < 16; k++)
        if (CODE_TAB[k] == code[d]) begin hit = 1'b1; v = 4'(k); end
      if (hit) dg[d] = v;
      else     f.err = 1'b1;
    end
    f.dg3 = dg[3]; f.dg2 = dg[2]; f.dg1 = dg[1]; f.dg0 = dg[0];
    f.err = f.err | multi;
    return f;
  endfunction

  task automatic put(input logic [3:0] com, input logic [7:0] seg, input int n);
    @(negedge clk);
    bus.I_COM     = ~com;
    bus.I_DRV7SEG = ~seg;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    logic [26:0] o;
    o = {bus.O_DG3, bus.O_DG2, bus.O_DG1, bus.O_DG0, bus.O_DOTS, bus.O_DRVEN,
         bus.O_VALID, bus.O_ERR};
    n_cmp++;
    assert (o === 27'h0) else begin
      n_bad++;
      $error("FAIL %s outputs=%h expected=%h", tag, o, 27'h0);
    end
  endtask

  task automatic chk_none(input string tag);
    n_cmp++;
    assert (obs_q.size() == 0) else begin
      n_bad++;
      $error("FAIL %s frames=%0d expected=0", tag, obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic chk_frame(input string tag, input frame_t e);
    frame_t o;
    n_cmp++;
    assert (obs_q.size() == 1) else begin
      n_bad++;
      $error("FAIL %s_count frames=%0d expected=1", tag, obs_q.size());
    end
    o = (obs_q.size() > 0) ? obs_q[0] : 'x;
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s frame=%h expected=%h", tag, o, e);
    end
    obs_q.delete();
  endtask

  // One full scan 3..0; the frame of the previous scan publishes during this one
  task automatic scan(input string tag, input logic [3:0] pres, input logic [3:0][6:0] code,
                      input logic [3:0] dp, input bit multi, input bit glitch);
    for (int d = 3; d >= 0; d--) begin
      if (pres[d]) begin
        if (glitch && d == 2) begin
          put(4'(1 << d), {dp[d], code[d] ^ 7'h08}, 2);
          put(4'(1 << d), {dp[d], code[d]}, 18);
        end else begin
          put(4'(1 << d), {dp[d], code[d]}, 20);
        end
        put(4'h0, 8'h00, 2);
      end
      if (multi && d == 1) begin
        put(4'b0011, 8'h00, 20);
        put(4'h0, 8'h00, 2);
      end
    end
    exp_q.push_back(model(pres, code, dp, multi));
    if (exp_q.size() >= 2) chk_frame(tag, exp_q.pop_front());
    else                   chk_none(tag);
  endtask

  logic [3:0][6:0] clean, hexabc, badseg, rcode;
  logic [3:0]      rdp;

  initial begin
    clean  = {7'h06, 7'h5B, 7'h4F, 7'h66};
    hexabc = {7'h77, 7'h7C, 7'h00, 7'h39};
    badseg = {7'h06, 7'h7E, 7'h4F, 7'h66};
    bus.I_COM     = 4'hF;
    bus.I_DRV7SEG = 8'hFF;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    scan("first",   4'hF,    clean,  4'b0001, 1'b0, 1'b0);
    scan("clean_a", 4'hF,    clean,  4'b0001, 1'b0, 1'b0);
    scan("glitch",  4'hF,    clean,  4'b0001, 1'b0, 1'b1);
    scan("missing", 4'b1101, hexabc, 4'b0000, 1'b0, 1'b0);
    scan("badseg",  4'hF,    badseg, 4'b0001, 1'b0, 1'b0);
    scan("clean_b", 4'hF,    clean,  4'b0001, 1'b0, 1'b0);
    scan("multi",   4'hF,    clean,  4'b0001, 1'b1, 1'b0);
    scan("clean_c", 4'hF,    clean,  4'b0001, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      for (int d = 0; d < 4; d++) begin
        rcode[d] = ($urandom_range(7) == 0) ? 7'h00 : CODE_TAB[$urandom_range(15)];
        rdp[d]   = 1'($urandom_range(1));
      end
      scan("rand", 4'hF, rcode, rdp, 1'b0, 1'b0);
    end
    scan("rand_last", 4'hF, clean, 4'b1010, 1'b0, 1'b0);

    // Reset in the middle of a scan
    put(4'b1000, {1'b0, 7'h06}, 20);
    put(4'h0, 8'h00, 2);
    put(4'b0100, {1'b0, 7'h5B}, 10);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    bus.I_COM     = 4'hF;
    bus.I_DRV7SEG = 8'hFF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();

`ifdef DRV7SEGRX_TIMEOUT_EN
    for (int i = 0; i < TMO + 50 && obs_q.size() == 0; i++) @(negedge clk);
    chk_frame("timeout", frame_t'(0));
`else
    repeat (TMO + 50) @(negedge clk);
    chk_none("hold");
    chk_zero("hold_out");
`endif

    scan("post_a", 4'hF, clean,  4'b0001, 1'b0, 1'b0);
    scan("post_b", 4'hF, hexabc, 4'b0100, 1'b0, 1'b0);
    scan("post_c", 4'hF, clean,  4'b0001, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/drv7seg_rx.md
# drv7seg_rx

Receiving end of the multiplexed 4-digit 7-segment bus (`SEG = {COM[3:0], DRV7SEG[7:0]}`). It samples the scanned COM and segment lines and filters out scan glitches. It decodes each lit digit back to a 4-bit hex value plus dot, and publishes one complete frame per scan cycle. It is used on-board as a loopback checker for the display path and as a bench monitor. It sits on the `s_clk` domain beside the display driver and taps `SEG`.

## Interface
- `STABLE_CYC`, 4: consecutive identical samples required before a (COM, SEG) pattern is accepted; must be ≥1.
- `TIMEOUT_CYC`, 4096: idle cycles with no accepted pattern before a forced frame publish; only used when `DRV7SEGRX_TIMEOUT_EN` is defined.
- `COM_ACTIVE_LOW`, 1: a COM bit at 0 selects its digit.
- `SEG_ACTIVE_LOW`, 1: a segment bit at 0 is lit.
- `I_CLK` input 1: single clock, `s_clk` domain.
- `I_RESET` input 1: asynchronous, active-high reset.
- `I_COM` input 4: digit commons; bit n is digit n.
- `I_DRV7SEG` input 8: segments `{dp,g,f,e,d,c,b,a}`, bit 7 down to bit 0.
- `O_DG3`, `O_DG2`, `O_DG1`, `O_DG0` output 4 each: decoded hex digit values of the last published frame.
- `O_DOTS` output 4: dp state per digit.
- `O_DRVEN` output 4: digit was lit with a non-blank pattern during the frame.
- `O_VALID` output 1: one-cycle pulse when the frame outputs update.
- `O_ERR` output 1: last published frame held an undecodable pattern or a multi-hot COM.

## Operation
- Both input buses pass through a 2-flop synchronizer. Polarity is normalised after it, so internally 1 means selected or lit.
- Stability filter:
  - A counter clears whenever the normalised {com, seg} differs from the previous cycle.
  - The pattern is accepted on the cycle the counter reaches `STABLE_CYC-1`.
  - The counter saturates after that, so each stable run yields exactly one accept.
- Classification of an accepted pattern:
  - com == 0 (blanking gap): ignored.
  - com multi-hot: sets the frame error bit; nothing else changes.
  - com one-hot, digit n: n is the capture candidate.
- Frame FSM has states `IDLE`, `COLLECT` and `PUBLISH`.
  - `IDLE` → `COLLECT` on the first one-hot accept. Shadow registers are cleared and digit n is captured.
  - In `COLLECT`, a one-hot accept for a digit not yet in the capture mask is captured and its mask bit is set.
  - In `COLLECT`, a one-hot accept for a digit already in the mask → `PUBLISH`.
  - `PUBLISH` copies the shadow registers to the outputs and pulses `O_VALID` for one cycle. It then restarts `COLLECT` with a cleared shadow, and the repeated digit becomes the first capture of the new frame.
- Capture of digit n:
  - The segment code goes through `seg7_decode` (canonical codes 0–F).
  - All segments a–g off → `DRVEN[n]=0` and `DG[n]=0`.
  - An unknown code → `DG[n]=0`, `DRVEN[n]=1` and the frame error bit is set.
  - `DOTS[n]` takes the dp bit regardless of the code.
- Digits never selected during a frame publish `DRVEN=0`, `DG=0`, `DOTS=0`.
- `O_ERR` is updated only at publish, from the frame error bit.
- Reset, at any time including mid-frame:
  - All outputs go to 0 and the FSM to `IDLE`.
  - The synchronizers, filter counter, mask and shadow registers clear.

## Timing
- A pattern present on the pins from edge t is accepted at edge t+2+`STABLE_CYC`.
- Publish happens one cycle after the accept that closes the frame. `O_VALID` is high in that cycle and the outputs are valid from that same edge.
- A simultaneous COM and SEG change counts as one change and restarts the filter once.
- A glitch shorter than `STABLE_CYC` cycles is never accepted.
- One frame is published per full scan. With the default driver, `O_VALID` has a period of 4 digit slots.

## Configuration
- `DRV7SEGRX_TIMEOUT_EN` defined:
  - A counter of width clog2(`TIMEOUT_CYC`+1) runs in `COLLECT` and clears on every accept.
  - When it reaches `TIMEOUT_CYC`, the block publishes the partial frame, pulses `O_VALID` and returns to `IDLE`.
  - In `IDLE` it publishes an all-zero frame once per `TIMEOUT_CYC`, so a dark display reads `O_DRVEN=0`.
- Not defined: no timeout logic. Outputs hold their last frame indefinitely.

## Structure
- Shared package holds:
  - the 16 canonical segment codes (`{g..a}`) and the blank code;
  - the FSM state enum;
  - segment bit-index constants (`SEG_DP=7` … `SEG_A=0`).
- One sub-module, `seg7_decode`, is purely combinational. It takes 7 bits in and returns a 4-bit value, a `blank` flag and an `invalid` flag.

## Test plan
- Scan digits 3,2,1,0 showing 1,2,3,4, dp on digit 0, 20-cycle slots with 2-cycle gaps → one `O_VALID` per scan, `DG3..0`=1,2,3,4, `O_DOTS`=0001, `O_DRVEN`=1111, `O_ERR`=0.
- Same scan with a 2-cycle wrong segment glitch (`STABLE_CYC`=4) inside the digit-2 slot → outputs identical to the clean scan.
- Digit 1 never selected, others show A,B,–,C → `O_DRVEN`=1101 and `DG1`=0.
- Digit 2 shows code 0x7F with segment a off (not in the table) → `O_ERR`=1, `DG2`=0, `O_DRVEN[2]`=1; the next clean frame gives `O_ERR`=0.
- COM=0011 held stable → frame error set, `O_ERR`=1 at the next publish.
- Assert `I_RESET` mid-frame, then stop scanning with the timeout build → all outputs 0 immediately. After `TIMEOUT_CYC` cycles, `O_VALID` pulses with all outputs 0.
